// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch sequencer.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      VALID = 2'd3
   } fetch_state_t;

   localparam int BYTES_PER_INSTR = 4;
   localparam int PC_STEP         = 4;

endpackage

// File: rtl/instr_byte_assembler.sv
// Shift register that builds a big-endian instruction word one byte at a time.
// The first byte shifted in ends up in the most significant position.
module instr_byte_assembler
   import instr_fetch_pkg::*;
#(
   parameter int DATA_WIDTH        = 8,
   parameter int INSTRUCTION_WIDTH = BYTES_PER_INSTR * DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         shift_en,
   input  logic [DATA_WIDTH-1:0]        byte_in,
   output logic [INSTRUCTION_WIDTH-1:0] word
);

   logic [INSTRUCTION_WIDTH-1:0] word_d;
   logic [INSTRUCTION_WIDTH-1:0] word_q;

   // Clear wins over shift so a byte returning after a redirect is dropped.
   always_comb begin
      word_d = word_q;
      if (clear) begin
         word_d = '0;
      end else if (shift_en) begin
         word_d = {word_q[INSTRUCTION_WIDTH-DATA_WIDTH-1:0], byte_in};
      end
   end

   // Capture register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: issues four byte reads per instruction to a
// 1-cycle-latency memory, assembles them big-endian and hands the word to
// decode over valid/ready. A redirect restarts fetch at a new PC.
//
// state | meaning
// BOOT  | first cycle out of reset, no read issued
// ISSUE | one byte read per cycle at pc+cnt, cnt 0..3
// DRAIN | no read; last byte of the word is captured
// VALID | instr/instr_pc presented, waiting for instr_ready
module instr_fetch_seq
   import instr_fetch_pkg::*;
#(
   parameter int                     ADDRESS_WIDTH     = 32,
   parameter int                     DATA_WIDTH        = 8,
   parameter int                     INSTRUCTION_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC        = 32'h0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
   output logic                         mem_rd_en,
   output logic [ADDRESS_WIDTH-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_rdata,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [INSTRUCTION_WIDTH-1:0] instr,
   output logic [ADDRESS_WIDTH-1:0]     instr_pc,
   output logic                         busy
);

   localparam int CNT_W = $clog2(BYTES_PER_INSTR);

   fetch_state_t             state_d, state_q;
   logic [ADDRESS_WIDTH-1:0] pc_d, pc_q;
   logic [CNT_W-1:0]         cnt_d, cnt_q;
   logic                     rd_pending_d, rd_pending_q;
   logic                     asm_clear;

   // Next-state, PC/counter update and read strobe. Redirect overrides all
   // states, including an accepting handshake in VALID.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      mem_rd_en = 1'b0;
      asm_clear = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = ISSUE;
         end
         ISSUE: begin
            mem_rd_en = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTES_PER_INSTR - 1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = VALID;
         end
         VALID: begin
            if (instr_ready) begin
               state_d = ISSUE;
               pc_d    = pc_q + ADDRESS_WIDTH'(PC_STEP);
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      if (redirect_valid) begin
         state_d   = ISSUE;
         pc_d      = redirect_pc;
         cnt_d     = '0;
         asm_clear = 1'b1;
      end
   end

   // A read issued in the redirect cycle belongs to the abandoned fetch, so
   // its returning byte must not be captured.
   always_comb begin
      rd_pending_d = mem_rd_en & ~redirect_valid;
   end

   // State, PC, byte counter and outstanding-read flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         cnt_q        <= '0;
         rd_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   instr_byte_assembler #(
      .DATA_WIDTH        (DATA_WIDTH),
      .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
   ) u_assembler (
      .clk      (clk),
      .rst      (rst),
      .clear    (asm_clear),
      .shift_en (rd_pending_q),
      .byte_in  (mem_rdata),
      .word     (instr)
   );

   // Address wraps modulo 2^ADDRESS_WIDTH; cnt is zero outside ISSUE.
   assign mem_addr    = pc_q + {{(ADDRESS_WIDTH-CNT_W){1'b0}}, cnt_q};
   assign instr_pc    = pc_q;
   assign instr_valid = (state_q == VALID);
   assign busy        = (state_q == ISSUE) || (state_q == DRAIN);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq. Inputs are driven and outputs sampled on
// the falling edge; a behavioural byte memory answers reads one cycle later.
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_ready;

   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        busy;

   logic        w_mem_rd_en;
   logic [31:0] w_mem_addr;
   logic [7:0]  w_mem_rdata = 8'h00;
   logic        w_instr_valid;
   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;
   logic        w_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_seq #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .busy(busy)
   );

   instr_fetch_seq #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
      .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .mem_rd_en(w_mem_rd_en), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
      .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr),
      .instr_pc(w_instr_pc), .busy(w_busy)
   );

   // Memory contents: bytes 0..3 fixed, everything else low address byte ^ A5.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0:   return 8'h13;
         32'h1:   return 8'h05;
         32'h2:   return 8'hA0;
         32'h3:   return 8'h00;
         default: return a[7:0] ^ 8'hA5;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem_byte(mem_addr);
      if (w_mem_rd_en) w_mem_rdata <= mem_byte(w_mem_addr);
   end

   task automatic apply_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (w_mem_addr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL reset_wrap_addr: got %h expected fffffffe", w_mem_addr); end
      checks++; if (w_instr_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL reset_wrap_pc: got %h expected fffffffe", w_instr_pc); end
      rst = 1'b0;
   endtask

   task automatic test_basic_fetch();
      instr_ready = 1'b1;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'(i) || busy !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL basic_issue c%0d: rd_en=%b addr=%h busy=%b valid=%b expected 1 %h 1 0", i, mem_rd_en, mem_addr, busy, instr_valid, i);
         end
      end
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL basic_drain: rd_en=%b busy=%b valid=%b expected 0 1 0", mem_rd_en, busy, instr_valid);
      end
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h1305A000 || instr_pc !== 32'h0 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_valid: valid=%b instr=%h pc=%h rd_en=%b busy=%b expected 1 1305a000 0 0 0", instr_valid, instr, instr_pc, mem_rd_en, busy);
      end
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h4 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL basic_next: rd_en=%b addr=%h valid=%b expected 1 4 0", mem_rd_en, mem_addr, instr_valid);
      end
      instr_ready = 1'b0;
   endtask

   task automatic test_stall();
      repeat (5) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hA1A0A3A2 || instr_pc !== 32'h4) begin
         errors++; $display("FAIL stall_valid: valid=%b instr=%h pc=%h expected 1 a1a0a3a2 4", instr_valid, instr, instr_pc);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (instr_valid !== 1'b1 || instr !== 32'hA1A0A3A2 || instr_pc !== 32'h4 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL stall_hold %0d: valid=%b instr=%h pc=%h rd_en=%b expected 1 a1a0a3a2 4 0", i, instr_valid, instr, instr_pc, mem_rd_en);
         end
      end
      instr_ready = 1'b1;
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h8 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL stall_release: rd_en=%b addr=%h valid=%b expected 1 8 0", mem_rd_en, mem_addr, instr_valid);
      end
   endtask

   task automatic test_redirect_with_accept();
      repeat (5) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hADACAFAE || instr_pc !== 32'h8) begin
         errors++; $display("FAIL accept_valid: valid=%b instr=%h pc=%h expected 1 adacafae 8", instr_valid, instr, instr_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h80 + 32'(i) || instr_valid !== 1'b0) begin
            errors++; $display("FAIL accept_redirect_addr %0d: rd_en=%b addr=%h valid=%b expected 1 %h 0", i, mem_rd_en, mem_addr, instr_valid, 32'h80 + 32'(i));
         end
      end
      repeat (2) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h25242726 || instr_pc !== 32'h80) begin
         errors++; $display("FAIL accept_redirect_word: valid=%b instr=%h pc=%h expected 1 25242726 80", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_redirect_mid_issue();
      repeat (3) @(negedge clk);
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h86) begin
         errors++; $display("FAIL mid_pre: rd_en=%b addr=%h expected 1 86", mem_rd_en, mem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h40 + 32'(i) || instr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_redirect_addr %0d: rd_en=%b addr=%h valid=%b expected 1 %h 0", i, mem_rd_en, mem_addr, instr_valid, 32'h40 + 32'(i));
         end
      end
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_drain_valid: got %b expected 0", instr_valid); end
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hE5E4E7E6 || instr_pc !== 32'h40) begin
         errors++; $display("FAIL mid_redirect_word: valid=%b instr=%h pc=%h expected 1 e5e4e7e6 40", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL b2b_first: addr=%h expected 100", mem_addr); end
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h200) begin
         errors++; $display("FAIL b2b_second: rd_en=%b addr=%h expected 1 200", mem_rd_en, mem_addr);
      end
      repeat (5) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hA5A4A7A6 || instr_pc !== 32'h200) begin
         errors++; $display("FAIL b2b_word: valid=%b instr=%h pc=%h expected 1 a5a4a7a6 200", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_reset_mid_drain();
      instr_ready = 1'b1;
      apply_reset();
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1 || mem_rd_en !== 1'b0 || instr === 32'h0) begin
         errors++; $display("FAIL drain_pre: busy=%b rd_en=%b instr=%h expected 1 0 nonzero", busy, mem_rd_en, instr);
      end
      rst = 1'b1;
      #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || mem_addr !== 32'h0 || instr_pc !== 32'h0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         errors++; $display("FAIL drain_reset: valid=%b instr=%h addr=%h pc=%h busy=%b rd_en=%b expected all zero", instr_valid, instr, mem_addr, instr_pc, busy, mem_rd_en);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h1305A000 || instr_pc !== 32'h0) begin
         errors++; $display("FAIL drain_restart: valid=%b instr=%h pc=%h expected 1 1305a000 0", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wrap_addr [4];
      wrap_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (w_mem_rd_en !== 1'b1 || w_mem_addr !== wrap_addr[i]) begin
            errors++; $display("FAIL wrap_addr %0d: rd_en=%b addr=%h expected 1 %h", i, w_mem_rd_en, w_mem_addr, wrap_addr[i]);
         end
      end
      repeat (2) @(negedge clk);
      checks++; if (w_instr_valid !== 1'b1 || w_instr !== 32'h5B5A1305 || w_instr_pc !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL wrap_word: valid=%b instr=%h pc=%h expected 1 5b5a1305 fffffffe", w_instr_valid, w_instr, w_instr_pc);
      end
      @(negedge clk);
      checks++; if (w_mem_addr !== 32'h2) begin errors++; $display("FAIL wrap_next_addr: addr=%h expected 2", w_mem_addr); end
      repeat (5) @(negedge clk);
      checks++; if (w_instr_valid !== 1'b1 || w_instr !== 32'hA000A1A0 || w_instr_pc !== 32'h2) begin
         errors++; $display("FAIL wrap_next_word: valid=%b instr=%h pc=%h expected 1 a000a1a0 2", w_instr_valid, w_instr, w_instr_pc);
      end
   endtask

   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_with_accept();
      test_redirect_mid_issue();
      test_back_to_back();
      test_reset_mid_drain();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
